// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmit serializer among NUM_REQ
// byte-stream requesters. Round-robin arbitration at packet granularity,
// one byte in flight at a time, optional idle gap after every packet.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int GAP_CYCLES    = 16,
  parameter int MAX_PKT_BYTES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_done
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [GW-1:0] GAP_LAST = GAP_LAST_I[GW-1:0];
  localparam logic [7:0]    MAX_B    = MAX_PKT_BYTES[7:0];
  localparam int RR_INIT_I = NUM_REQ - 1;
  localparam logic [IW-1:0] RR_INIT = RR_INIT_I[IW-1:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr;       // last winner; doubles as granted index
  logic [7:0]      byte_cnt;
  logic            last_r;
  logic [GW-1:0]   gap_cnt;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_oh;
  logic            load_win;     // IDLE: capture winner
  logic            hs;           // LOAD: byte handshake on granted lane
  logic            pkt_end;      // WAIT: tx_done closes the packet
  logic            done_ok;      // tx_done that is allowed to count
  logic [7:0]      lane_byte;

  // Round-robin search: first valid index after rr_ptr, wrapping.
  // Iterating from the farthest offset down lets the nearest one win.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      logic [IW-1:0] idx;
      idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // One-hot form of the winner, loaded into grant.
  always_comb begin
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
  end

  assign lane_byte = req_data[{rr_ptr, 3'b000} +: 8];

  // A tx_done coinciding with our own tx_start belongs to nothing we sent.
  assign done_ok = tx_done && !tx_start;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and per-state strobes.
  always_comb begin
    state_nxt = state;
    load_win  = 1'b0;
    hs        = 1'b0;
    pkt_end   = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          load_win  = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        // Granted requester may stall indefinitely; grant is held.
        if (req_valid[rr_ptr]) begin
          hs        = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (done_ok) begin
          if (last_r || byte_cnt == MAX_B) begin
            pkt_end   = 1'b1;
            state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is a pure pass-through of the granted lane's valid while loading.
  always_comb begin
    req_ready = '0;
    if (state == LOAD) req_ready[rr_ptr] = req_valid[rr_ptr];
  end

  assign busy = (state != IDLE);

  // Datapath: grant, round-robin pointer, byte capture, counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant    <= '0;
      rr_ptr   <= RR_INIT;
      byte_cnt <= '0;
      last_r   <= 1'b0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      tx_start <= hs;
      if (load_win) begin
        grant    <= win_oh;
        rr_ptr   <= win_idx;
        byte_cnt <= '0;
      end
      if (hs) begin
        tx_data <= lane_byte;
        last_r  <= req_last[rr_ptr];
        if (byte_cnt != 8'hFF) byte_cnt <= byte_cnt + 8'd1;
      end
      if (pkt_end) grant <= '0;
      if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
      else              gap_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter. Requesters are queues of bytes;
// a packet-level round-robin model predicts the (owner, byte) sequence
// the serializer must see. A serializer model answers with tx_done after
// a random delay and injects spurious tx_done pulses that must be ignored.
module tb_uart_tx_arbiter;
  localparam int N    = 4;
  localparam int GAP  = 16;
  localparam int MAXB = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_done;

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP), .MAX_PKT_BYTES(MAXB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant), .busy(busy),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [8:0]  rq [N][$];      // per requester: {last, byte}
  int          exp_own[$];
  logic [7:0]  exp_byte[$];
  int          mptr;           // model's last winner
  logic [N-1:0] hs_pend;
  int          stall [N];
  int          ser_cnt;
  bit          ser_busy;
  int          gap_run;

  // Reference: serve whole packets in round-robin order from the loaded
  // queues, cutting a packet after MAXB bytes.
  function automatic void build();
    logic [8:0] cq [N][$];
    for (int i = 0; i < N; i++) cq[i] = rq[i];
    forever begin
      int w, cnt;
      bit f, lst;
      f = 0; w = 0;
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (mptr + k) % N;
        if (!f && cq[j].size() > 0) begin w = j; f = 1; end
      end
      if (!f) break;
      mptr = w; cnt = 0; lst = 0;
      while (!lst && cnt < MAXB && cq[w].size() > 0) begin
        logic [8:0] e;
        e = cq[w].pop_front();
        exp_own.push_back(w);
        exp_byte.push_back(e[7:0]);
        cnt++;
        lst = e[8];
      end
    end
  endfunction

  task automatic add_pkt(input int i, input int len);
    for (int b = 0; b < len; b++) rq[i].push_back({(b == len - 1), 8'($urandom)});
  endtask

  task automatic clr_model();
    for (int i = 0; i < N; i++) begin rq[i].delete(); stall[i] = 0; end
    exp_own.delete(); exp_byte.delete();
    mptr = N - 1; ser_busy = 0; ser_cnt = 0; gap_run = 0; hs_pend = '0;
  endtask

  // One clock: retire last edge's handshakes, run serializer model and
  // monitors, drive requester lanes for the next edge.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (hs_pend[i] && rq[i].size() > 0) void'(rq[i].pop_front());

    tx_done = 1'b0;
    if (tx_start) begin
      chk("overlap", 32'(ser_busy), 0);
      if (exp_own.size() == 0) chk("unexp_start", 32'(tx_start), 0);
      else begin
        int o;
        logic [7:0] b;
        o = exp_own.pop_front();
        b = exp_byte.pop_front();
        chk("tx_data", 32'(tx_data), 32'(b));
        chk("owner", 32'(grant), 32'(1 << o));
      end
      ser_busy = 1;
      ser_cnt  = $urandom_range(1, 6);
      if ($urandom % 4 == 0) tx_done = 1'b1;   // coincident with tx_start
    end else if (ser_busy) begin
      ser_cnt--;
      if (ser_cnt == 0) begin ser_busy = 0; tx_done = 1'b1; end
    end else if ($urandom % 8 == 0) begin
      tx_done = 1'b1;                           // spurious, serializer idle
    end

    if (grant == '0 && busy) gap_run++;
    else if (gap_run != 0) begin chk("gap_len", gap_run, GAP); gap_run = 0; end

    for (int i = 0; i < N; i++) begin
      if (!grant[i]) stall[i] = 0;
      else if (stall[i] > 0) stall[i]--;
      else if ($urandom % 32 == 0) stall[i] = ($urandom % 8 == 0) ? 100 : $urandom_range(1, 12);
      req_valid[i] = (rq[i].size() > 0) && (stall[i] == 0);
      req_data[i*8 +: 8] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
      req_last[i] = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
    end
    #1;
    hs_pend = req_valid & req_ready;
    chk("ready_in_grant", 32'(req_ready & ~grant), 0);
  endtask

  task automatic drain();
    int left;
    for (int c = 0; c < 20000; c++) begin
      left = exp_own.size();
      for (int i = 0; i < N; i++) left += rq[i].size();
      if (left == 0 && !ser_busy && !busy) break;
      step();
    end
    left = exp_own.size() + 32'(busy);
    for (int i = 0; i < N; i++) left += rq[i].size();
    chk("drain", left, 0);
  endtask

  task automatic do_reset();
    clr_model();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    clr_model();
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_done = 1'b0;
    do_reset();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(tx_start), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_ready", 32'(req_ready), 0);

    // Single requester, three bytes; exact first-byte latency.
    rq[0].push_back({1'b0, 8'h41});
    rq[0].push_back({1'b0, 8'h42});
    rq[0].push_back({1'b1, 8'h43});
    build();
    step();
    step();
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_nostart", 32'(tx_start), 0);
    step();
    chk("t1_start", 32'(tx_start), 1);
    chk("t1_data", 32'(tx_data), 32'h41);
    drain();

    // Long packet forced to split, with another requester pending.
    add_pkt(1, 70);
    add_pkt(3, 2);
    build();
    drain();

    // Everyone requesting, two one-byte packets each.
    for (int i = 0; i < N; i++) begin add_pkt(i, 1); add_pkt(i, 1); end
    build();
    drain();

    // Random mixes of requesters and packet lengths.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++)
        if ($urandom % 4 != 0) begin
          int np;
          np = $urandom_range(1, 3);
          for (int p = 0; p < np; p++)
            add_pkt(i, ($urandom % 10 == 0) ? $urandom_range(60, 70) : $urandom_range(1, 10));
        end
      build();
      drain();
    end

    // Reset while a byte is in flight.
    rq[2].push_back({1'b1, 8'h55});
    build();
    for (int c = 0; c < 50 && !tx_start; c++) step();
    chk("t6_inflight", 32'(tx_start), 1);
    chk("t6_data", 32'(tx_data), 32'h55);
    rst = 1'b1;
    step();
    chk("t6_grant", 32'(grant), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_start", 32'(tx_start), 0);
    chk("t6_data0", 32'(tx_data), 0);
    chk("t6_ready", 32'(req_ready), 0);
    rst = 1'b0;
    clr_model();
    add_pkt(3, 2);
    add_pkt(1, 3);
    build();
    step();
    step();
    chk("t6_lowest", 32'(grant), 32'h2);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
